// File: rtl/output_buffer_ctrl.sv
// Sequences the output buffer through its bit-plane capture/accumulate passes, zero-point correction and result unload.
// Optional debug pass counter port pass_cnt_o is compiled in by defining OBUF_CTRL_PASS_CNT_EN.
module output_buffer_ctrl #(
  parameter int NUM_GROUPS = 32,
  parameter int CNT_W      = 5,
  parameter int ITER_W     = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic [2:0]        pim_mode_i,
  input  logic [ITER_W-1:0] num_iter_i,
  input  logic              zp_apply_i,
  input  logic              flash_valid_i,
  input  logic              load_req_i,
  output logic              buf_write_en_1_o,
  output logic              buf_write_en_2_o,
  output logic              buf_read_en_o,
  output logic              shift_counter_en_o,
  output logic [2:0]        pim_mode_o,
  output logic              zero_point_en_o,
  output logic              load_en_o,
  output logic [CNT_W-1:0]  load_cnt_o,
  output logic              load_valid_o,
  output logic              busy_o,
`ifdef OBUF_CTRL_PASS_CNT_EN
  output logic [ITER_W-1:0] pass_cnt_o,
`endif
  output logic              done_o
);

  typedef enum logic [2:0] {IDLE, W1, W2, RD, ACC, ZP, LOAD, FIN} state_t;

  localparam logic [ITER_W-1:0] ITER_ONE = ITER_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]  LAST_IDX = CNT_W'(NUM_GROUPS - 1);

  state_t            state_q, state_d;
  logic [ITER_W-1:0] num_iter_q, num_iter_d, iter_cnt_q, iter_cnt_d;
  logic              zp_apply_q, zp_apply_d;
  logic [CNT_W-1:0]  idx_q, idx_d, cnt_d;
  logic [2:0]        mode_d;
  logic              wr1_d, wr2_d, rd_d, shift_d, zp_d, ld_d, vld_d, done_d;

  // Every strobe is registered, so each one appears the cycle after the state that decided it.
  always_comb begin
    state_d    = state_q;
    num_iter_d = num_iter_q;
    iter_cnt_d = iter_cnt_q;
    zp_apply_d = zp_apply_q;
    idx_d      = idx_q;
    cnt_d      = load_cnt_o;
    mode_d     = pim_mode_o;
    wr1_d      = 1'b0;
    wr2_d      = 1'b0;
    rd_d       = 1'b0;
    shift_d    = 1'b0;
    zp_d       = 1'b0;
    ld_d       = 1'b0;
    done_d     = 1'b0;
    vld_d      = load_en_o & ~abort_i;
    if (abort_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: if (start_i) begin
          mode_d     = pim_mode_i;
          num_iter_d = (num_iter_i == '0) ? ITER_ONE : num_iter_i;
          zp_apply_d = zp_apply_i;
          iter_cnt_d = '0;
          idx_d      = '0;
          state_d    = W1;
        end
        W1: if (flash_valid_i) begin
          wr1_d   = 1'b1;
          state_d = W2;
        end
        W2: if (flash_valid_i) begin
          wr2_d   = 1'b1;
          state_d = RD;
        end
        RD: begin
          rd_d    = 1'b1;
          state_d = ACC;
        end
        ACC: begin
          shift_d    = 1'b1;
          iter_cnt_d = iter_cnt_q + ITER_ONE;
          if (iter_cnt_q + ITER_ONE == num_iter_q) state_d = zp_apply_q ? ZP : LOAD;
          else                                     state_d = W1;
        end
        ZP: begin
          zp_d    = 1'b1;
          state_d = LOAD;
        end
        LOAD: if (load_req_i) begin
          ld_d  = 1'b1;
          cnt_d = idx_q;
          if (idx_q == LAST_IDX) state_d = FIN;
          else                   idx_d   = idx_q + CNT_ONE;
        end
        FIN: begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q            <= IDLE;
      num_iter_q         <= '0;
      iter_cnt_q         <= '0;
      zp_apply_q         <= 1'b0;
      idx_q              <= '0;
      load_cnt_o         <= '0;
      pim_mode_o         <= '0;
      buf_write_en_1_o   <= 1'b0;
      buf_write_en_2_o   <= 1'b0;
      buf_read_en_o      <= 1'b0;
      shift_counter_en_o <= 1'b0;
      zero_point_en_o    <= 1'b0;
      load_en_o          <= 1'b0;
      load_valid_o       <= 1'b0;
      done_o             <= 1'b0;
      busy_o             <= 1'b0;
    end else begin
      state_q            <= state_d;
      num_iter_q         <= num_iter_d;
      iter_cnt_q         <= iter_cnt_d;
      zp_apply_q         <= zp_apply_d;
      idx_q              <= idx_d;
      load_cnt_o         <= cnt_d;
      pim_mode_o         <= mode_d;
      buf_write_en_1_o   <= wr1_d;
      buf_write_en_2_o   <= wr2_d;
      buf_read_en_o      <= rd_d;
      shift_counter_en_o <= shift_d;
      zero_point_en_o    <= zp_d;
      load_en_o          <= ld_d;
      load_valid_o       <= vld_d;
      done_o             <= done_d;
      busy_o             <= (state_d != IDLE);
    end
  end

`ifdef OBUF_CTRL_PASS_CNT_EN
  assign pass_cnt_o = iter_cnt_q;
`endif

endmodule

// File: tb/tb_output_buffer_ctrl.sv
// Bench for output_buffer_ctrl: fixed-scenario table, directed corner sequences, and randomized ops against an event-schedule model.
module tb_output_buffer_ctrl;
  localparam int TMAX = 320;
  localparam int B_WR1 = 8, B_WR2 = 7, B_RD = 6, B_SH = 5, B_ZP = 4, B_LD = 3, B_VLD = 2, B_DONE = 1, B_BUSY = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_ni, start_i, abort_i, zp_apply_i, flash_valid_i, load_req_i;
  logic [2:0] pim_mode_i, pim_mode_o;
  logic [3:0] num_iter_i;
  logic       buf_write_en_1_o, buf_write_en_2_o, buf_read_en_o, shift_counter_en_o;
  logic       zero_point_en_o, load_en_o, load_valid_o, busy_o, done_o;
  logic [4:0] load_cnt_o;
`ifdef OBUF_CTRL_PASS_CNT_EN
  logic [3:0] pass_cnt_o;
`endif

  output_buffer_ctrl dut (
    .clk_i(clk), .rst_ni(rst_ni), .start_i(start_i), .abort_i(abort_i),
    .pim_mode_i(pim_mode_i), .num_iter_i(num_iter_i), .zp_apply_i(zp_apply_i),
    .flash_valid_i(flash_valid_i), .load_req_i(load_req_i),
    .buf_write_en_1_o(buf_write_en_1_o), .buf_write_en_2_o(buf_write_en_2_o),
    .buf_read_en_o(buf_read_en_o), .shift_counter_en_o(shift_counter_en_o),
    .pim_mode_o(pim_mode_o), .zero_point_en_o(zero_point_en_o),
    .load_en_o(load_en_o), .load_cnt_o(load_cnt_o), .load_valid_o(load_valid_o),
    .busy_o(busy_o),
`ifdef OBUF_CTRL_PASS_CNT_EN
    .pass_cnt_o(pass_cnt_o),
`endif
    .done_o(done_o)
  );

  int checks = 0;
  int errors = 0;

  bit         st[TMAX], ab[TMAX], rs[TMAX], fv[TMAX], rq[TMAX];
  logic [8:0] tr_s[TMAX], e_s[TMAX];
  logic [4:0] tr_cnt[TMAX], e_cnt[TMAX];
  logic [2:0] tr_mode[TMAX];

  typedef struct {
    logic [3:0] niter;
    bit         zp;
    logic [2:0] mode;
    int         shifts;
    int         zps;
    int         first_ld;
    int         done_cyc;
  } row_t;
  row_t rows[5];

  task automatic chk(input string name, input int n, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, n, got, exp);
    end
  endtask

  task automatic clear_stim();
    for (int i = 0; i < TMAX; i++) begin
      st[i] = 0; ab[i] = 0; rs[i] = 0; fv[i] = 1; rq[i] = 1;
    end
  endtask

  // Cycle n's inputs are applied, then the outputs seen after the edge are recorded as cycle n+1.
  task automatic run(input int ncyc, input logic [2:0] mode, input logic [3:0] niter, input bit zp);
    for (int n = 0; n < ncyc; n++) begin
      start_i = st[n]; abort_i = ab[n]; rst_ni = !rs[n];
      flash_valid_i = fv[n]; load_req_i = rq[n];
      if (st[n]) begin
        pim_mode_i = mode; num_iter_i = niter; zp_apply_i = zp;
      end else begin
        pim_mode_i = 3'($urandom); num_iter_i = 4'($urandom); zp_apply_i = 1'($urandom);
      end
      @(posedge clk); #1;
      tr_s[n+1]    = {buf_write_en_1_o, buf_write_en_2_o, buf_read_en_o, shift_counter_en_o,
                      zero_point_en_o, load_en_o, load_valid_o, done_o, busy_o};
      tr_cnt[n+1]  = load_cnt_o;
      tr_mode[n+1] = pim_mode_o;
    end
    start_i = 0; abort_i = 0; rst_ni = 1; flash_valid_i = 0; load_req_i = 0;
  endtask

  // Event schedule for an op started in cycle 0: each strobe lands one cycle after the deciding input.
  task automatic model(input logic [3:0] niter, input bit zp, output int last);
    int passes, c, r, k;
    for (int i = 0; i < TMAX; i++) begin e_s[i] = '0; e_cnt[i] = '0; end
    passes = (niter == 0) ? 1 : int'(niter);
    c = 1;
    for (int p = 0; p < passes; p++) begin
      while (!fv[c] && c < TMAX - 8) c++;
      e_s[c+1][B_WR1] = 1'b1;
      c = c + 1;
      while (!fv[c] && c < TMAX - 8) c++;
      e_s[c+1][B_WR2] = 1'b1;
      e_s[c+2][B_RD]  = 1'b1;
      e_s[c+3][B_SH]  = 1'b1;
      c = c + 3;
    end
    if (zp) begin e_s[c+1][B_ZP] = 1'b1; c = c + 1; end
    k = 0; r = c;
    while (k < 32 && r < TMAX - 4) begin
      if (rq[r]) begin
        e_s[r+1][B_LD] = 1'b1; e_cnt[r+1] = 5'(k); e_s[r+2][B_VLD] = 1'b1; k++;
      end
      r++;
    end
    last = r + 1;
    e_s[last][B_DONE] = 1'b1;
    for (int i = 1; i < last; i++) e_s[i][B_BUSY] = 1'b1;
  endtask

  task automatic compare_model(input string name, input int upto, input logic [2:0] mode);
    for (int n = 1; n <= upto; n++) begin
      chk({name, "_outs"}, n, 32'(tr_s[n]), 32'(e_s[n]));
      chk({name, "_mode"}, n, 32'(tr_mode[n]), 32'(mode));
      if (e_s[n][B_LD]) chk({name, "_cnt"}, n, 32'(tr_cnt[n]), 32'(e_cnt[n]));
    end
  endtask

  initial begin
    int last, sp, nsh, nzp, fld, fdone, excl, lag, cseq, zpc, shc, fw1, fw2, nz;
    logic [2:0] m;
    logic [3:0] ni;
    bit z;

    rows[0] = '{4'd3,  1'b0, 3'd5, 3,  0, 14, 46};
    rows[1] = '{4'd0,  1'b1, 3'd2, 1,  1, 7,  39};
    rows[2] = '{4'd1,  1'b0, 3'd7, 1,  0, 6,  38};
    rows[3] = '{4'd2,  1'b1, 3'd1, 2,  1, 11, 43};
    rows[4] = '{4'd15, 1'b1, 3'd3, 15, 1, 63, 95};

    start_i = 0; abort_i = 0; flash_valid_i = 0; load_req_i = 0;
    pim_mode_i = 0; num_iter_i = 0; zp_apply_i = 0;
    rst_ni = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", 0, 32'({buf_write_en_1_o, buf_write_en_2_o, buf_read_en_o, shift_counter_en_o,
                               zero_point_en_o, load_en_o, load_valid_o, done_o, busy_o, load_cnt_o, pim_mode_o}), 32'(0));
    rst_ni = 1;

    // Fixed scenarios with flash and requests always ready.
    for (int t = 0; t < 5; t++) begin
      clear_stim(); st[0] = 1;
      run(110, rows[t].mode, rows[t].niter, rows[t].zp);
      nsh = 0; nzp = 0; fld = -1; fdone = -1; excl = 0; lag = 0; cseq = 0; zpc = -1; shc = -1;
      for (int n = 1; n <= 110; n++) begin
        if (tr_s[n][B_SH]) begin nsh++; shc = n; end
        if (tr_s[n][B_ZP]) begin nzp++; zpc = n; end
        if (tr_s[n][B_LD] && fld < 0) fld = n;
        if (tr_s[n][B_DONE] && fdone < 0) fdone = n;
        if ($countones(tr_s[n][8:3]) > 1) excl++;
        if (n > 1 && tr_s[n][B_VLD] != tr_s[n-1][B_LD]) lag++;
        if (tr_s[n][B_LD] && fld >= 0 && int'(tr_cnt[n]) != n - fld) cseq++;
      end
      chk("tbl_shifts", t, 32'(nsh), 32'(rows[t].shifts));
      chk("tbl_zp_count", t, 32'(nzp), 32'(rows[t].zps));
      chk("tbl_first_load", t, 32'(fld), 32'(rows[t].first_ld));
      chk("tbl_done_cycle", t, 32'(fdone), 32'(rows[t].done_cyc));
      chk("tbl_mode_hold", t, 32'(tr_mode[110]), 32'(rows[t].mode));
      chk("tbl_exclusive", t, 32'(excl), 32'(0));
      chk("tbl_valid_lag", t, 32'(lag), 32'(0));
      chk("tbl_cnt_seq", t, 32'(cseq), 32'(0));
      if (rows[t].zps == 1) chk("tbl_zp_after_shift", t, 32'(zpc), 32'(shc + 1));
    end

    // Flash stalls: 5 low cycles in W1, 3 in W2.
    clear_stim(); st[0] = 1;
    for (int n = 1; n <= 5; n++) fv[n] = 0;
    for (int n = 7; n <= 9; n++) fv[n] = 0;
    model(4'd1, 1'b0, last);
    run(last + 3, 3'd4, 4'd1, 1'b0);
    compare_model("stall", last + 2, 3'd4);
    fw1 = -1; fw2 = -1;
    for (int n = 1; n <= 20; n++) begin
      if (tr_s[n][B_WR1] && fw1 < 0) fw1 = n;
      if (tr_s[n][B_WR2] && fw2 < 0) fw2 = n;
    end
    chk("stall_wr1_cycle", 0, 32'(fw1), 32'(7));
    chk("stall_wr2_cycle", 0, 32'(fw2), 32'(11));

    // Gapped loads, with a start pulse while busy and flash toggling during LOAD.
    clear_stim(); st[0] = 1; st[30] = 1;
    for (int n = 5; n < TMAX; n++) begin
      rq[n] = (n < 69) && ((n - 5) % 2 == 0);
      fv[n] = (n % 3 != 0);
    end
    model(4'd1, 1'b0, last);
    run(last + 3, 3'd6, 4'd1, 1'b0);
    compare_model("gap", last + 2, 3'd6);
    chk("gap_done_cycle", 0, 32'(tr_s[69][B_DONE]), 32'(1));
    chk("gap_last_cnt", 0, 32'(tr_cnt[68]), 32'(31));

    // Abort at load index 10, abort beating a start in IDLE, then a fresh op.
    clear_stim(); st[0] = 1; ab[15] = 1; st[17] = 1; ab[17] = 1; st[18] = 1;
    run(70, 3'd2, 4'd1, 1'b0);
    chk("abort_cnt_before", 15, 32'(tr_cnt[15]), 32'(9));
    chk("abort_quiet", 16, 32'(tr_s[16]), 32'(0));
    chk("abort_beats_start", 18, 32'(tr_s[18]), 32'(0));
    chk("restart_w1", 19, 32'(tr_s[19]), 32'(9'b000000001));
    chk("restart_wr1", 20, 32'(tr_s[20]), 32'(9'b100000001));
    chk("restart_load0", 24, 32'({tr_s[24], tr_cnt[24]}), 32'({9'b000001001, 5'd0}));
    chk("restart_done", 56, 32'(tr_s[56]), 32'(9'b000000110));

    // Synchronous reset in the middle of the second ACC.
    clear_stim(); st[0] = 1; rs[8] = 1;
    run(40, 3'd6, 4'd3, 1'b0);
    chk("rst_mid_acc", 9, 32'({tr_s[9], tr_cnt[9], tr_mode[9]}), 32'(0));
    nz = 0;
    for (int n = 10; n <= 40; n++) if (tr_s[n] != 0 || tr_mode[n] != 0) nz++;
    chk("rst_stays_idle", 0, 32'(nz), 32'(0));

    // Randomized ops against the schedule model.
    for (int it = 0; it < 20; it++) begin
      clear_stim(); st[0] = 1;
      m = 3'($urandom); ni = 4'($urandom_range(0, 4)); z = 1'($urandom);
      for (int n = 1; n < 150; n++) begin
        fv[n] = 1'($urandom_range(0, 1));
        rq[n] = 1'($urandom_range(0, 1));
      end
      model(ni, z, last);
      sp = $urandom_range(1, last - 1);
      st[sp] = 1;
      run(last + 3, m, ni, z);
      compare_model("rand", last + 2, m);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
